// File: rtl/booth_mult_seq_if.sv
// Issue-side bundle for the sequential Booth multiplier.
// The master side (ALU issue logic) drives start and operands; the slave side (multiplier) returns status and result.
interface booth_mult_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  busy;
    logic                  result_rdy;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;

    modport master (
        output start, operand_a, operand_b,
        input  busy, result_rdy, result, overflow
    );

    modport slave (
        input  start, operand_a, operand_b,
        output busy, result_rdy, result, overflow
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-2 Booth signed multiplier. One iteration per clock; result_rdy pulses 32 cycles after start.
// Flow control is start/busy only: a start seen while busy is dropped, and no result is ever stalled.
module booth_mult_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    booth_mult_seq_if.slave  bus
);
    localparam int PW = 2*DATA_WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         prod;
    logic [DATA_WIDTH-1:0] mcand;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  overflow_q;

    logic [DATA_WIDTH:0]   acc_cur;
    logic [DATA_WIDTH:0]   mcand_ext;
    logic [DATA_WIDTH:0]   addend;
    logic                  cin;
    logic [DATA_WIDTH:0]   acc_new;
    logic [PW-1:0]         prod_next;
    logic                  ovf_next;
    logic                  last_iter;

    assign acc_cur   = prod[PW-1:DATA_WIDTH+1];
    assign mcand_ext = {mcand[DATA_WIDTH-1], mcand};
    assign last_iter = (cnt == CNT_WIDTH'(DATA_WIDTH-1));

    // Subtraction is the inverted multiplicand plus a carry-in of one.
    always_comb begin
        addend = '0;
        cin    = 1'b0;
        case (prod[1:0])
            2'b01:   addend = mcand_ext;
            2'b10: begin
                addend = ~mcand_ext;
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
        acc_new   = acc_cur + addend + {{DATA_WIDTH{1'b0}}, cin};
        prod_next = {acc_new[DATA_WIDTH], acc_new, prod[DATA_WIDTH:1]};
        // The product fits only if bits 2W..W of the shifted register are all equal.
        ovf_next  = ~((&prod_next[2*DATA_WIDTH:DATA_WIDTH]) |
                      ~(|prod_next[2*DATA_WIDTH:DATA_WIDTH]));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            prod       <= '0;
            mcand      <= '0;
            cnt        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.operand_a;
                        prod  <= {{(DATA_WIDTH+1){1'b0}}, bus.operand_b, 1'b0};
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    prod <= prod_next;
                    cnt  <= cnt + CNT_WIDTH'(1);
                    if (last_iter) begin
                        result_q   <= prod_next[DATA_WIDTH:1];
                        overflow_q <= ovf_next;
                        state      <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == S_RUN) || (state == S_DONE);
    assign bus.result_rdy = (state == S_DONE);
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth signed multiplier for the multdiv unit.
- Holds a 66-bit product register {acc[32:0], multiplier[31:0], q_extra}. Each iteration adds or subtracts the multiplicand into the accumulator, then arithmetic-shifts the whole register right by 1.
- Produces a 32-bit truncated result plus an overflow flag after 32 iterations, with a start/ready handshake to the ALU issue logic.

Parameters:
- DATA_WIDTH, 32, operand and result width. The product register is 2*DATA_WIDTH+2 bits. Only 32 is verified.
- CNT_WIDTH, 5, iteration counter width, equal to log2(DATA_WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- operand_a  input  32  multiplicand, signed two's complement
- operand_b  input  32  multiplier, signed two's complement
- busy  output  1  high in RUN and DONE
- result_rdy  output  1  one-cycle pulse; result and overflow valid
- result  output  32  low 32 bits of the signed product
- overflow  output  1  product not representable in 32 signed bits

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all internal registers (product register, multiplicand, counter) cleared.
  - result=0, overflow=0, result_rdy=0, busy=0.
  - A reset mid-operation aborts the multiply; no result_rdy is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a clock edge with start=1: mcand<=operand_a; P<={33'b0, operand_b, 1'b0}; cnt<=0; go to RUN.
  - start=0 keeps the FSM in IDLE.
  - result and overflow hold their last values.
- RUN, one iteration per clock, driven by pair = {P[1], P[0]}:
  - 00 or 11: no add.
  - 01: acc += sext33(mcand).
  - 10: acc -= sext33(mcand).
  - Then P <= {acc_new[32], acc_new, P[32:1]}, an arithmetic shift right by 1 that replicates the MSB.
  - cnt increments each iteration.
  - Iteration with cnt==31 is the last: go to DONE and register result<=P_next[32:1].
  - Register overflow <= ~(all bits of P_next[64:32] equal), i.e. the 64-bit product P_next[64:1] does not sign-extend from bit 31.
- Arithmetic: acc is 33 bits and cannot overflow internally; subtraction is add of the inverted value with carry-in 1.
- DONE: result_rdy=1 for exactly this one cycle, busy=1; unconditional return to IDLE on the next edge.
- Latency: start sampled at edge 0, iterations at edges 1..32, result_rdy high between edges 32 and 33.
- Throughput: a new start is accepted in the cycle following DONE (back-to-back issue, 34-cycle period).
- start while busy (RUN or DONE) is ignored. Operands are not re-latched, and the in-flight result is unaffected.
- Operands may change after the start edge without affecting the result.
- result and overflow are registered, stable from the DONE cycle until the next completed multiply or reset.
- busy and result_rdy are decoded from state registers only, with no combinational path from inputs.

Test Plan:
- Basic signed cases, each checked with result_rdy exactly 32 cycles after start:
  - a=3, b=5 -> result=15, overflow=0.
  - a=-7 (0xFFFFFFF9), b=6 -> result=0xFFFFFFD6 (-42), overflow=0.
  - a=-1, b=-1 -> result=1, overflow=0.
- Overflow cases:
  - a=0x7FFFFFFF, b=2 -> result=0xFFFFFFFE, overflow=1.
  - a=0x80000000, b=-1 -> result=0x80000000, overflow=1.
  - a=0x80000000, b=1 -> result=0x80000000, overflow=0.
- Zero and boundary: a=0, b=0x80000000 -> result=0, overflow=0. a=0x00010000, b=0x00010000 -> result=0, overflow=1.
- Start while busy: start a=3, b=5, then pulse start with a=9, b=9 at cycle 10 -> single result_rdy at cycle 32, result=15. busy stays high through cycle 32 and drops in cycle 33.
- Reset mid-op: start a=100, b=100, assert reset_n=0 at cycle 15 (asynchronously, between edges) -> busy=0, result=0, overflow=0 immediately. No result_rdy follows. A new start a=4, b=4 after release yields 16 at +32 cycles.
- Back-to-back: start 6*7, then start -3*3 in the cycle after result_rdy -> 42, then -9 (0xFFFFFFF7), with result_rdy pulses 34 cycles apart. Random signed operands (1000 iterations) are checked against a 64-bit golden product for result and overflow.
